// File: rtl/fixed_point_pkg.sv
// Shared definitions for the fixed-point arithmetic units.
package fixed_point_pkg;

    localparam int unsigned FP_WIDTH = 16;
    localparam int unsigned FP_FRAC  = 8;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        FIX,
        DONE
    } fp_state_t;

    // Largest positive two's complement value of the given width (0x7F..F).
    function automatic logic [63:0] fp_max(input int unsigned width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    // Bit pattern of the most negative value of the given width (0x80..0).
    function automatic logic [63:0] fp_min(input int unsigned width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/fixed_point_saturate.sv
// Applies a sign to an unsigned magnitude and clamps it into a signed WIDTH word.
module fixed_point_saturate
    import fixed_point_pkg::*;
#(
    parameter int unsigned WIDTH = FP_WIDTH,
    parameter int unsigned MAG_W = FP_WIDTH + FP_FRAC
) (
    input  logic             i_sign,
    input  logic [MAG_W-1:0] i_mag,
    output logic [WIDTH-1:0] o_result,
    output logic             o_overflow
);

    localparam logic [WIDTH-1:0] W_MAX   = WIDTH'(fp_max(WIDTH));
    localparam logic [WIDTH-1:0] W_MIN   = WIDTH'(fp_min(WIDTH));
    localparam logic [MAG_W-1:0] POS_LIM = MAG_W'(W_MAX);
    localparam logic [MAG_W-1:0] NEG_LIM = MAG_W'(W_MIN);

    // Clamp positive magnitudes above MAX and negative magnitudes above |MIN|.
    always_comb begin
        o_result   = '0;
        o_overflow = 1'b0;
        if (!i_sign) begin
            if (i_mag > POS_LIM) begin
                o_result   = W_MAX;
                o_overflow = 1'b1;
            end else begin
                o_result = i_mag[WIDTH-1:0];
            end
        end else begin
            if (i_mag > NEG_LIM) begin
                o_result   = W_MIN;
                o_overflow = 1'b1;
            end else if (i_mag == NEG_LIM) begin
                o_result = W_MIN;
            end else begin
                o_result = '0 - i_mag[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/fixed_point_divider.sv
// Sequential signed fixed-point divider: restoring division on magnitudes,
// one quotient bit per cycle, followed by sign application and saturation.
module fixed_point_divider
    import fixed_point_pkg::*;
#(
    parameter int unsigned WIDTH = FP_WIDTH,
    parameter int unsigned FRAC  = FP_FRAC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             start,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             div_by_zero,
    output logic             busy,
    output logic             done
);

    localparam int unsigned QW    = WIDTH + FRAC;
    localparam int unsigned CNT_W = (QW > 1) ? $clog2(QW) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(QW - 1);

    fp_state_t        r_state;
    fp_state_t        w_next_state;
    logic             r_sign;
    logic             r_dbz;
    logic [WIDTH-1:0] r_divisor;
    logic [QW-1:0]    r_dividend;
    logic [WIDTH:0]   r_rem;
    logic [QW-1:0]    r_quot;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_overflow;
    logic             r_div_by_zero;

    logic             w_start_ok;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [QW-1:0]    w_sat_mag;
    logic [WIDTH-1:0] w_sat_result;
    logic             w_sat_ovf;

    assign w_start_ok = start && (r_state == IDLE || r_state == DONE);
    assign w_abs_a    = a[WIDTH-1] ? '0 - a : a;
    assign w_abs_b    = b[WIDTH-1] ? '0 - b : b;

    // The remainder stays below the divisor, so only its low WIDTH bits feed the shift.
    assign w_trial = {r_rem[WIDTH-1:0], r_dividend[QW-1]};
    assign w_diff  = w_trial - {1'b0, r_divisor};
    assign w_ge    = r_rem[WIDTH] || (w_trial >= {1'b0, r_divisor});

    // Divide-by-zero reuses the saturator: an all-ones magnitude clamps toward the sign of a.
    assign w_sat_mag = r_dbz ? '1 : r_quot;

    fixed_point_saturate #(
        .WIDTH (WIDTH),
        .MAG_W (QW)
    ) u_saturate (
        .i_sign     (r_sign),
        .i_mag      (w_sat_mag),
        .o_result   (w_sat_result),
        .o_overflow (w_sat_ovf)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, DONE: if (start) w_next_state = (b == '0) ? FIX : DIVIDE;
            DIVIDE:     if (r_cnt == '0) w_next_state = FIX;
            FIX:        w_next_state = DONE;
            default:    w_next_state = IDLE;
        endcase
    end

    // Operand capture, restoring division steps and output registration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign        <= 1'b0;
            r_dbz         <= 1'b0;
            r_divisor     <= '0;
            r_dividend    <= '0;
            r_rem         <= '0;
            r_quot        <= '0;
            r_cnt         <= '0;
            r_result      <= '0;
            r_overflow    <= 1'b0;
            r_div_by_zero <= 1'b0;
        end else if (w_start_ok) begin
            r_sign     <= a[WIDTH-1] ^ b[WIDTH-1];
            r_dbz      <= (b == '0);
            r_divisor  <= w_abs_b;
            r_dividend <= QW'(w_abs_a) << FRAC;
            r_rem      <= '0;
            r_quot     <= '0;
            r_cnt      <= CNT_INIT;
        end else if (r_state == DIVIDE) begin
            r_rem      <= w_ge ? w_diff : w_trial;
            r_quot     <= {r_quot[QW-2:0], w_ge};
            r_dividend <= r_dividend << 1;
            r_cnt      <= r_cnt - 1'b1;
        end else if (r_state == FIX) begin
            r_result      <= w_sat_result;
            r_overflow    <= w_sat_ovf | r_dbz;
            r_div_by_zero <= r_dbz;
        end
    end

    assign result      = r_result;
    assign overflow    = r_overflow;
    assign div_by_zero = r_div_by_zero;
    assign busy        = (r_state == DIVIDE) || (r_state == FIX);
    assign done        = (r_state == DONE);

endmodule
